// File: rtl/inst_queue_pkg.sv
// Shared definitions for the ID-side instruction queue.
// Holds the IF->ID bus layout, stall-bus encoding, queue sizing defaults,
// the queue entry format and a small pop-count helper.
package inst_queue_pkg;

  localparam int STALLBUS_WD  = 6;
  localparam int IF_TO_ID_WD  = 1 + 1 + 32 + 32;
  localparam int IQ_TO_ID_WD  = 2 * (1 + 32 + 32);

  localparam logic NO_STOP = 1'b0;
  localparam logic STOP    = 1'b1;

  localparam int INST_Q_DEPTH = 16;
  localparam int INST_Q_AFULL = 4;

  // {discard, ce, pc_idef, pc_reg} as driven by IF
  typedef struct packed {
    logic        discard;
    logic        ce;
    logic [31:0] pc_idef;
    logic [31:0] pc_reg;
  } if_req_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } iq_entry_t;

  localparam int ENTRY_W = $bits(iq_entry_t);

  // ID can take at most two per cycle; an encoding of 3 means "as many as possible"
  function automatic logic [1:0] sat_pop(input logic [1:0] n);
    return (n == 2'd3) ? 2'd2 : n;
  endfunction

endpackage

// File: rtl/inst_queue_ram.sv
// Queue storage: DEPTH x 64-bit register file.
// Ports:
//   clk            clock
//   we0/we1        write enables for entries at waddr and waddr+1
//   waddr          base write pointer
//   wdata0/wdata1  entries written at waddr / waddr+1
//   raddr          base read pointer
//   rdata0/rdata1  asynchronous reads at raddr / raddr+1
// Both +1 addresses wrap mod DEPTH, so a pair can straddle the end of the array.
module inst_queue_ram
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = INST_Q_DEPTH
) (
  input  logic                     clk,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  iq_entry_t                wdata0,
  input  iq_entry_t                wdata1,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output iq_entry_t                rdata0,
  output iq_entry_t                rdata1
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][ENTRY_W-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]              waddr1, raddr1;

  assign waddr1 = waddr + PTR_W'(1);
  assign raddr1 = raddr + PTR_W'(1);

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (we0 && (waddr == PTR_W'(i)))  mem_d[i] = wdata0;
      if (we1 && (waddr1 == PTR_W'(i))) mem_d[i] = wdata1;
    end
  end

  // Storage is not reset: contents are only observable behind the valid flags.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata0 = iq_entry_t'(mem_q[raddr]);
  assign rdata1 = iq_entry_t'(mem_q[raddr1]);

endmodule

// File: rtl/inst_queue.sv
// ID-side instruction queue.
// Captures each IF fetch request, pairs it with the 64-bit SRAM word returned
// one cycle later, enqueues one or two instructions, and presents up to two
// instructions per cycle to ID.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   stall            stall bus, only bit 0 gates fetch capture
//   flush            exception/ERET flush, kills queue and in-flight fetch
//   if_to_id_bus     {discard, ce, pc_idef, pc_reg} from IF
//   inst_sram_rdata  {word at pc_reg+4, word at pc_reg}, one cycle after request
//   pop_num          instructions ID consumes this cycle (3 treated as 2)
//   inst0_*/inst1_*  two oldest queue slots
//   stallreq_iq      queue near full, hold IF
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH        = INST_Q_DEPTH,
  parameter int AFULL_MARGIN = INST_Q_AFULL
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALLBUS_WD-1:0] stall,
  input  logic                   flush,
  input  logic [IF_TO_ID_WD-1:0] if_to_id_bus,
  input  logic [63:0]            inst_sram_rdata,
  input  logic [1:0]             pop_num,
  output logic                   inst0_valid,
  output logic [31:0]            inst0_pc,
  output logic [31:0]            inst0,
  output logic                   inst1_valid,
  output logic [31:0]            inst1_pc,
  output logic [31:0]            inst1,
  output logic                   stallreq_iq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] AFULL_LVL = CNT_W'(DEPTH - AFULL_MARGIN);

  if_req_t req;
  assign req = if_req_t'(if_to_id_bus);

  logic             resp_vld_q, resp_vld_d;
  logic [31:0]      resp_pc_q,  resp_pc_d;
  logic             resp_hi_q,  resp_hi_d;
  logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [CNT_W-1:0] count_q,    count_d;
  logic             stallreq_q, stallreq_d;

  logic [1:0]       push_n, pop_sat, pop_eff;
  logic             we0, we1;
  iq_entry_t        wdata0, wdata1, rdata0, rdata1;

  // Only the high-order bits of the stall bus and the in-word offset of
  // pc_idef beyond bit 2 carry nothing for this block.
  logic unused_ok;
  assign unused_ok = ^{stall[STALLBUS_WD-1:1], req.pc_idef[31:3], req.pc_idef[1:0]};

  always_comb begin
    // Request capture: discarded, stalled or flushed requests never reach the queue.
    resp_vld_d = req.ce & (stall[0] == NO_STOP) & ~req.discard & ~flush;
    resp_pc_d  = req.pc_reg;
    resp_hi_d  = req.pc_idef[2];

    // A branch target in the high word leaves only one useful instruction.
    push_n  = resp_vld_q ? (resp_hi_q ? 2'd1 : 2'd2) : 2'd0;

    pop_sat = sat_pop(pop_num);
    pop_eff = (CNT_W'(pop_sat) > count_q) ? count_q[1:0] : pop_sat;

    rd_ptr_d = rd_ptr_q + PTR_W'(pop_eff);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
    count_d  = count_q + CNT_W'(push_n) - CNT_W'(pop_eff);

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end

    // Registered near-full: the margin absorbs the response already in flight
    // plus the request IF issues before the stall reaches it.
    stallreq_d = ~flush & (count_d >= AFULL_LVL);
  end

  always_comb begin
    we0    = resp_vld_q & ~flush;
    we1    = resp_vld_q & ~resp_hi_q & ~flush;
    wdata0 = resp_hi_q ? '{pc: resp_pc_q + 32'd4, inst: inst_sram_rdata[63:32]}
                       : '{pc: resp_pc_q,         inst: inst_sram_rdata[31:0]};
    wdata1 = '{pc: resp_pc_q + 32'd4, inst: inst_sram_rdata[63:32]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_vld_q <= 1'b0;
      resp_pc_q  <= '0;
      resp_hi_q  <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      stallreq_q <= 1'b0;
    end else begin
      resp_vld_q <= resp_vld_d;
      resp_pc_q  <= resp_pc_d;
      resp_hi_q  <= resp_hi_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      stallreq_q <= stallreq_d;
    end
  end

  inst_queue_ram #(.DEPTH(DEPTH)) u_ram (
    .clk    (clk),
    .we0    (we0),
    .we1    (we1),
    .waddr  (wr_ptr_q),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .raddr  (rd_ptr_q),
    .rdata0 (rdata0),
    .rdata1 (rdata1)
  );

  // Invalid slots read as zero so that reset leaves every output at 0
  // even though the storage itself is not cleared.
  assign inst0_valid = (count_q != '0);
  assign inst1_valid = (count_q >= CNT_W'(2));
  assign inst0_pc    = inst0_valid ? rdata0.pc   : '0;
  assign inst0       = inst0_valid ? rdata0.inst : '0;
  assign inst1_pc    = inst1_valid ? rdata1.pc   : '0;
  assign inst1       = inst1_valid ? rdata1.inst : '0;
  assign stallreq_iq = stallreq_q;

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int DEPTH = 16;
  localparam int AFULL = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [STALLBUS_WD-1:0] stall;
  logic                   flush;
  logic [IF_TO_ID_WD-1:0] if_to_id_bus;
  logic [63:0]            inst_sram_rdata;
  logic [1:0]             pop_num;
  logic                   inst0_valid, inst1_valid, stallreq_iq;
  logic [31:0]            inst0_pc, inst0, inst1_pc, inst1;

  inst_queue #(.DEPTH(DEPTH), .AFULL_MARGIN(AFULL)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .if_to_id_bus(if_to_id_bus), .inst_sram_rdata(inst_sram_rdata),
    .pop_num(pop_num),
    .inst0_valid(inst0_valid), .inst0_pc(inst0_pc), .inst0(inst0),
    .inst1_valid(inst1_valid), .inst1_pc(inst1_pc), .inst1(inst1),
    .stallreq_iq(stallreq_iq)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  string tname  = "init";

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        sb[$];         // entries visible to ID, oldest first
  logic        infl = 1'b0;   // request accepted last cycle, data arrives now
  logic        infl_hi = 1'b0;
  logic [31:0] infl_pc = '0;
  logic [63:0] infl_data = '0;
  logic [63:0] pend_rdata = '0;
  logic        exp_stall = 1'b0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  function automatic logic [63:0] rd(input logic [31:0] pc);
    return {word(pc + 32'd4), word(pc)};
  endfunction

  // One clock cycle: drive IF/ID inputs, compare the DUT's slots against the
  // scoreboard head, then advance the model across the clock edge.
  // rdat is the SRAM word this request will return on the next cycle.
  task automatic step(input logic ce, input logic disc, input logic stl, input logic fl,
                      input logic [31:0] pcr, input logic [31:0] pcd,
                      input logic [63:0] rdat, input logic [1:0] pop);
    int   pops;
    int   n;
    ent_t e;
    stall           = {{(STALLBUS_WD-1){1'b0}}, stl};
    flush           = fl;
    if_to_id_bus    = {disc, ce, pcd, pcr};
    inst_sram_rdata = pend_rdata;
    pend_rdata      = rdat;
    pop_num         = pop;
    #1;
    checks++;
    if (inst0_valid !== (sb.size() >= 1)) begin
      errors++;
      $display("FAIL %s sb_inst0_valid: got %b exp %b", tname, inst0_valid, sb.size() >= 1);
    end
    if (sb.size() >= 1) begin
      checks++;
      if ({inst0_pc, inst0} !== {sb[0].pc, sb[0].inst}) begin
        errors++;
        $display("FAIL %s sb_slot0: got pc %h inst %h exp pc %h inst %h",
                 tname, inst0_pc, inst0, sb[0].pc, sb[0].inst);
      end
    end
    checks++;
    if (inst1_valid !== (sb.size() >= 2)) begin
      errors++;
      $display("FAIL %s sb_inst1_valid: got %b exp %b", tname, inst1_valid, sb.size() >= 2);
    end
    if (sb.size() >= 2) begin
      checks++;
      if ({inst1_pc, inst1} !== {sb[1].pc, sb[1].inst}) begin
        errors++;
        $display("FAIL %s sb_slot1: got pc %h inst %h exp pc %h inst %h",
                 tname, inst1_pc, inst1, sb[1].pc, sb[1].inst);
      end
    end
    checks++;
    if (stallreq_iq !== exp_stall) begin
      errors++;
      $display("FAIL %s sb_stallreq: got %b exp %b", tname, stallreq_iq, exp_stall);
    end

    pops = (pop == 2'd3) ? 2 : int'(pop);
    if (pops > sb.size()) pops = sb.size();

    @(posedge clk);
    #1;
    if (rst || fl) begin
      sb.delete();
      infl      = 1'b0;
      exp_stall = 1'b0;
    end else begin
      repeat (pops) void'(sb.pop_front());
      if (infl) begin
        n = infl_hi ? 1 : 2;
        checks++;
        if (sb.size() + n > DEPTH) begin
          errors++;
          $display("FAIL %s overflow: occupancy %0d exp <= %0d", tname, sb.size() + n, DEPTH);
        end
        if (!infl_hi) begin
          e.pc = infl_pc; e.inst = infl_data[31:0];
          sb.push_back(e);
        end
        e.pc = infl_pc + 32'd4; e.inst = infl_data[63:32];
        sb.push_back(e);
      end
      exp_stall = (sb.size() >= DEPTH - AFULL);
      infl      = ce & ~stl & ~disc;
      infl_hi   = pcd[2];
      infl_pc   = pcr;
      infl_data = rdat;
    end
  endtask

  task automatic idle(input logic [1:0] pop);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 64'h0, pop);
  endtask

  task automatic test_reset();
    tname = "reset";
    checks++;
    if ({inst0_valid, inst1_valid, stallreq_iq} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b exp 000", {inst0_valid, inst1_valid, stallreq_iq});
    end
    checks++;
    if ({inst0_pc, inst0, inst1_pc, inst1} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: got %h exp 0", {inst0_pc, inst0, inst1_pc, inst1});
    end
  endtask

  task automatic test_aligned();
    tname = "aligned";
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'hbfc0_0000, 32'hbfc0_0000, {32'h2402_0002, 32'h2401_0001}, 2'd0);
    idle(2'd0);
    checks++;
    if ({inst0_valid, inst1_valid} !== 2'b11) begin
      errors++;
      $display("FAIL aligned_valid: got %b exp 11", {inst0_valid, inst1_valid});
    end
    checks++;
    if ({inst0_pc, inst0} !== {32'hbfc0_0000, 32'h2401_0001}) begin
      errors++;
      $display("FAIL aligned_slot0: got %h %h exp bfc00000 24010001", inst0_pc, inst0);
    end
    checks++;
    if ({inst1_pc, inst1} !== {32'hbfc0_0004, 32'h2402_0002}) begin
      errors++;
      $display("FAIL aligned_slot1: got %h %h exp bfc00004 24020002", inst1_pc, inst1);
    end
    idle(2'd2);
  endtask

  task automatic test_high_word();
    tname = "high_word";
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'hbfc0_0010, 32'hbfc0_0014, {32'hcafe_0014, 32'hdead_0010}, 2'd0);
    idle(2'd0);
    checks++;
    if ({inst0_valid, inst1_valid} !== 2'b10) begin
      errors++;
      $display("FAIL high_word_valid: got %b exp 10", {inst0_valid, inst1_valid});
    end
    checks++;
    if ({inst0_pc, inst0} !== {32'hbfc0_0014, 32'hcafe_0014}) begin
      errors++;
      $display("FAIL high_word_slot0: got %h %h exp bfc00014 cafe0014", inst0_pc, inst0);
    end
    idle(2'd1);
  endtask

  task automatic test_discard();
    tname = "discard";
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1000, 32'h0000_1000, rd(32'h1000), 2'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_2008, 32'h0000_200c, rd(32'h2008), 2'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_3000, 32'h0000_3000, rd(32'h3000), 2'd0);
    idle(2'd0);
    idle(2'd0);
    idle(2'd2);
    checks++;
    if ({inst0_valid, inst1_valid} !== 2'b10) begin
      errors++;
      $display("FAIL discard_count: got %b exp 10", {inst0_valid, inst1_valid});
    end
    checks++;
    if (inst0_pc !== 32'h0000_200c) begin
      errors++;
      $display("FAIL discard_last_pc: got %h exp 0000200c", inst0_pc);
    end
    idle(2'd1);
  endtask

  task automatic test_fetch_stall();
    tname = "fetch_stall";
    repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_4000, 32'h0000_4000, rd(32'h4000), 2'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_4000, 32'h0000_4000, rd(32'h4000), 2'd0);
    idle(2'd0);
    idle(2'd2);
    checks++;
    if (inst0_valid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_stall_dup: got valid %b exp 0", inst0_valid);
    end
  endtask

  task automatic test_pop_clip();
    tname = "pop_clip";
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_6000, 32'h0000_6004, rd(32'h6000), 2'd0);
    idle(2'd0);
    idle(2'd3);
    checks++;
    if (inst0_valid !== 1'b0) begin
      errors++;
      $display("FAIL pop_clip_empty: got valid %b exp 0", inst0_valid);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_7000, 32'h0000_7000, rd(32'h7000), 2'd3);
    idle(2'd0);
    checks++;
    if ({inst0_valid, inst1_valid, inst0_pc} !== {2'b11, 32'h0000_7000}) begin
      errors++;
      $display("FAIL pop_clip_after: got %b %h exp 11 00007000", {inst0_valid, inst1_valid}, inst0_pc);
    end
    idle(2'd2);
  endtask

  task automatic test_fill();
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        stl;
    tname = "fill";
    pc = 32'h8000_0000;
    for (int i = 0; i < 16; i++) begin
      stl = stallreq_iq;
      step(1'b1, 1'b0, stl, 1'b0, pc, pc, rd(pc), 2'd0);
      if (!stl) pc = pc + 32'd8;
    end
    checks++;
    if (stallreq_iq !== 1'b1) begin
      errors++;
      $display("FAIL fill_stallreq: got %b exp 1", stallreq_iq);
    end
    next_pc = 32'h8000_0000;
    for (int i = 0; i < 20; i++) begin
      if (inst0_valid) begin
        checks++;
        if (inst0_pc !== next_pc) begin
          errors++;
          $display("FAIL fill_order: got pc %h exp %h", inst0_pc, next_pc);
        end
        next_pc = next_pc + 32'd4;
      end
      idle(2'd1);
    end
    checks++;
    if (next_pc !== 32'h8000_0038) begin
      errors++;
      $display("FAIL fill_total: last pc+4 %h exp 80000038", next_pc);
    end
    checks++;
    if ({inst0_valid, stallreq_iq} !== 2'b00) begin
      errors++;
      $display("FAIL fill_drained: got %b exp 00", {inst0_valid, stallreq_iq});
    end
  endtask

  task automatic test_flush();
    tname = "flush";
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_5000 + 32'(i * 8), 32'h0000_5000 + 32'(i * 8),
           rd(32'h0000_5000 + 32'(i * 8)), 2'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_5020, 32'h0000_5020, rd(32'h5020), 2'd0);
    checks++;
    if ({inst0_valid, inst1_valid, stallreq_iq} !== 3'b000) begin
      errors++;
      $display("FAIL flush_clear: got %b exp 000", {inst0_valid, inst1_valid, stallreq_iq});
    end
    idle(2'd0);
    idle(2'd0);
    checks++;
    if (inst0_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_inflight: got valid %b exp 0", inst0_valid);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] pc;
    logic [31:0] exp_pc;
    tname = "wrap";
    pc     = 32'h9000_0000;
    exp_pc = 32'h9000_0000;
    for (int i = 0; i < 42; i++) begin
      if (i >= 2) begin
        checks++;
        if ({inst0_valid, inst1_valid, inst0_pc, inst1_pc} !== {2'b11, exp_pc, exp_pc + 32'd4}) begin
          errors++;
          $display("FAIL wrap_seq: got %b %h %h exp 11 %h %h",
                   {inst0_valid, inst1_valid}, inst0_pc, inst1_pc, exp_pc, exp_pc + 32'd4);
        end
        exp_pc = exp_pc + 32'd8;
      end
      step(1'b1, 1'b0, 1'b0, 1'b0, pc, pc, rd(pc), 2'd2);
      pc = pc + 32'd8;
    end
    repeat (3) idle(2'd2);
  endtask

  task automatic test_reset_mid();
    tname = "reset_mid";
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_a000 + 32'(i * 8), 32'h0000_a000 + 32'(i * 8),
           rd(32'h0000_a000 + 32'(i * 8)), 2'd0);
    rst = 1'b1;
    idle(2'd0);
    rst = 1'b0;
    checks++;
    if ({inst0_valid, inst1_valid, stallreq_iq, inst0_pc, inst0, inst1_pc, inst1} !== 131'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %b %h %h exp all 0",
               {inst0_valid, inst1_valid, stallreq_iq}, inst0_pc, inst0);
    end
    idle(2'd0);
    idle(2'd0);
    checks++;
    if (inst0_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_inflight: got valid %b exp 0", inst0_valid);
    end
  endtask

  initial begin
    rst             = 1'b1;
    stall           = '0;
    flush           = 1'b0;
    if_to_id_bus    = '0;
    inst_sram_rdata = '0;
    pop_num         = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    test_aligned();
    test_high_word();
    test_discard();
    test_fetch_stall();
    test_pop_clip();
    test_fill();
    test_flush();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
